// File: rtl/encoder_arbiter_pkg.sv
// encoder_arbiter_pkg
// Shared constants and types for the four-requester round-robin arbiter.
//   N_REQ       number of requesters
//   IDX_W       width of the encoded grant index
//   HOLD_CNT_W  width of the grant hold counter (timeout build only)
//   arb_state_t arbiter FSM states
package encoder_arbiter_pkg;

  localparam int N_REQ      = 4;
  localparam int IDX_W      = 2;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/encoder_arbiter_onehot_enc.sv
// arb_onehot_enc
// Combinational one-hot to binary index encoder. An all-zero input encodes
// to index 0. The input is assumed to be one-hot or zero.
// Ports:
//   onehot  in   N_REQ-bit one-hot vector
//   idx     out  IDX_W-bit index of the set bit
module arb_onehot_enc
  import encoder_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  // Index bit gi is the OR of every one-hot position whose binary index has
  // bit gi set.
  genvar gi;
  for (gi = 0; gi < IDX_W; gi++) begin : g_bit
    logic [N_REQ-1:0] sel;
    always_comb begin
      sel = '0;
      for (int j = 0; j < N_REQ; j++) begin
        sel[j] = onehot[j] & j[gi];
      end
    end
    assign idx[gi] = |sel;
  end

endmodule

// File: rtl/encoder_arbiter.sv
// encoder_arbiter
// Four-requester round-robin arbiter with registered one-hot grant and
// encoded grant index. A grant is held until its owner drops its request;
// every release is followed by exactly one idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- limits each grant to HOLD_MAX
// consecutive cycles and pulses gnt_expired on a forced release.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   req[3:0]     in   level-sensitive requests
//   gnt[3:0]     out  registered one-hot grant (or zero)
//   num[1:0]     out  registered index of gnt (0 when gnt is zero)
//   gnt_valid    out  registered |gnt
//   gnt_expired  out  one-cycle forced-release pulse (0 without the macro)
module encoder_arbiter
  import encoder_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] num,
  output logic             gnt_valid,
  output logic             gnt_expired
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("encoder_arbiter: HOLD_MAX must be in 2..255");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic             found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  gnt_expired_q, gnt_expired_d;
`endif

  // num is derived from the next grant so both register on the same edge.
  arb_onehot_enc u_enc (
    .onehot (gnt_d),
    .idx    (num_d)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    found       = 1'b0;
    cand        = '0;
    win         = '0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    gnt_expired_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Search ptr, ptr+1, ... (2-bit wrap); first active request wins.
        for (int k = 0; k < N_REQ; k++) begin
          cand = ptr_q + IDX_W'(k);
          if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found) begin
          gnt_d   = N_REQ'(1) << win;
          ptr_d   = win + IDX_W'(1);
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          gnt_d = '0;
        end
      end

      GRANT: begin
        // num_q is the current owner's index.
        if (!req[num_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          gnt_d         = '0;
          state_d       = IDLE;
          gnt_expired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        end
`endif
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      num_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      num_q       <= num_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q    <= '0;
      gnt_expired_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      gnt_expired_q <= gnt_expired_d;
    end
  end

  assign gnt_expired = gnt_expired_q;
`else
  assign gnt_expired = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign num       = num_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/encoder_arbiter.md
# encoder_arbiter

Four-requester round-robin arbiter that shares one downstream resource among requesters 0–3. It issues a registered one-hot grant and a 2-bit encoded grant index in the same format as the 4-to-2 encoder output `num`. It holds each grant until the owner drops its request. It sits in front of the encoder datapath as its sequencing and sharing controller.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per owner. Used only when `ARB_TIMEOUT_EN` is defined. Legal range is 2–255.

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  4  request lines; bit i belongs to requester i, level-sensitive.
- `gnt`  output  4  one-hot grant, or all zeros; registered.
- `num`  output  2  binary index of the asserted `gnt` bit; 2'd0 when `gnt` is zero.
- `gnt_valid`  output  1  high when `gnt` is non-zero.
- `gnt_expired`  output  1  one-cycle pulse on a forced release. Tied to 0 without `ARB_TIMEOUT_EN`.

## Operation
- States are IDLE and GRANT.
- Rotating priority pointer `ptr[1:0]`:
  - search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4;
  - the first requester with `req` high wins.
- IDLE:
  - if any `req` bit is high, latch the winner, set `gnt` one-hot, set `ptr` to winner+1 (mod 4), and go to GRANT;
  - otherwise stay in IDLE with `gnt` at zero.
- GRANT:
  - while the owner's `req` bit stays high, hold `gnt` and `num` unchanged. Other `req` bits are ignored.
  - when the owner's `req` bit is low, clear `gnt` and return to IDLE.
- Each release inserts exactly one idle cycle (`gnt`=0) before the next grant. There is no back-to-back handoff.
- `num` is always the encoding of `gnt`: 4'b0001→0, 4'b0010→1, 4'b0100→2, 4'b1000→3. `gnt` is never multi-hot.
- Arithmetic for `ptr` is 2-bit and wraps 3→0 naturally.
- Reset (synchronous, any state, including mid-grant):
  - state goes to IDLE, `ptr` to 0, `gnt` to 4'b0000, `num` to 2'd0, `gnt_valid` to 0, `gnt_expired` to 0, and the hold counter to 0;
  - requests present during the reset cycle are not granted until the first cycle after `reset` deasserts.

## Timing
- Grant latency: `req` sampled at edge N gives `gnt` valid after edge N (visible in cycle N+1). Latency is one clock.
- Release: owner `req` low at edge M gives `gnt` zero after M. The next grant decision is made at M+1 and becomes visible after M+1.
- Requesters must keep `req` high until they see their own `gnt` bit. Dropping `req` earlier is legal; that requester simply is not granted.
- Simultaneous requests are resolved purely by `ptr`.
- A request arriving in the same cycle as a release competes at the next IDLE edge.
- All outputs come directly from flops. There is no combinational path from `req` to any output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - an 8-bit hold counter clears on entry to GRANT and increments every cycle in GRANT;
  - when it reaches HOLD_MAX−1 with the owner still requesting, the next edge clears `gnt`, pulses `gnt_expired` for one cycle, and returns to IDLE;
  - `ptr` has already moved past the owner, so another pending requester wins next;
  - if no other requester is pending, the same owner may be re-granted.
- Undefined: no counter is built, grants are held indefinitely, and `gnt_expired` is constant 0.

## Structure
- Package `encoder_arbiter_pkg` holds:
  - `N_REQ` = 4 and `IDX_W` = 2;
  - state enum `arb_state_t` {IDLE, GRANT};
  - `HOLD_CNT_W` = 8.
- Sub-module `arb_onehot_enc`: combinational 4-bit one-hot to 2-bit index encoder. It computes the next-state `num` from next-state `gnt`, and its result is registered in the parent.
- The round-robin search stays inline in the parent.

## Test plan
- Reset then single request:
  - after `reset`, `req`=4'b0100 → one cycle later `gnt`=4'b0100, `num`=2, `gnt_valid`=1;
  - drop `req` → next cycle `gnt`=0, `num`=0.
- Fairness: hold `req`=4'b1111 and have each owner drop its bit for one cycle after 2 grant cycles → grant order is 0,1,2,3,0, with exactly one idle cycle between grants.
- Priority wrap: grant requester 3, release it, then present `req`=4'b1001 → requester 0 wins (`num`=0) because `ptr` wrapped to 0.
- Reset mid-grant:
  - requester 2 owns the grant; assert `reset` for 1 cycle with `req`=4'b0110 held;
  - `gnt`=0 and `num`=0 during and after the reset edge;
  - the next grant goes to requester 1 (`ptr`=0 search order).
- Timeout (`ARB_TIMEOUT_EN`, HOLD_MAX=4):
  - requester 1 holds `req` with requester 2 also pending → `gnt`=4'b0010 for exactly 4 cycles, then `gnt_expired`=1 with `gnt`=0 for one cycle, then `gnt`=4'b0100;
  - without the macro the same stimulus keeps `gnt`=4'b0010 for 20+ cycles and `gnt_expired` stays 0.
- Invariant checks on every cycle: `gnt` has at most one bit set, `num` equals the encoding of `gnt`, and `gnt_valid` equals OR-reduce of `gnt`.
